// File: rtl/ysyx_22040237_rf_pkg.sv
// rtl/ysyx_22040237_rf_pkg.sv - shared defaults and helpers for the integer register file
package ysyx_22040237_rf_pkg;
  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam logic [63:0] REGS_INIT = 64'h0;

  function automatic int rf_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ysyx_22040237_rf_scoreboard.sv
// rtl/ysyx_22040237_rf_scoreboard.sv - per-register busy tracking, issue acceptance and busy count
module ysyx_22040237_rf_scoreboard
  import ysyx_22040237_rf_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = rf_aw(NREG),
  parameter int NWR  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_ready,
  input  logic [NWR-1:0]    wb_valid,
  input  logic [NWR*AW-1:0] wb_addr,
  output logic [NREG-1:0]   busy,
  output logic [AW:0]       busy_cnt
);
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [NREG-1:0] wb_hit;

  always_comb begin
    wb_hit = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wb_valid[j]) wb_hit[wb_addr[j*AW +: AW]] = 1'b1;
    end

    iss_ready = (iss_addr == '0) || !busy_q[iss_addr] || wb_hit[iss_addr];

    // Clears first, then the set, so a same-cycle issue keeps the register reserved.
    busy_d = busy_q & ~wb_hit;
    if (iss_valid && iss_ready && (iss_addr != '0)) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;

    cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d = cnt_d + (AW+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;
endmodule

// File: rtl/ysyx_22040237_regfile_sb.sv
// rtl/ysyx_22040237_regfile_sb.sv - multi-port register file with write-back bypass and busy scoreboard
module ysyx_22040237_regfile_sb
  import ysyx_22040237_rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int AW     = rf_aw(NREG),
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_ready,
  input  logic [NWR-1:0]      wb_valid,
  input  logic [NWR*AW-1:0]   wb_addr,
  input  logic [NWR*XLEN-1:0] wb_data,
  output logic [AW:0]         busy_cnt,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);
  logic [XLEN-1:0] regs_q [1:NREG-1];
  logic [XLEN-1:0] regs_d [1:NREG-1];
  logic [NREG-1:0] busy;
  logic [AW-1:0]   ra;
  logic            fwd;
  logic [XLEN-1:0] fwd_data;

  ysyx_22040237_rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .NWR  (NWR)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  // Ascending port order makes the highest-index write-back win on a collision.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (wb_valid[j] && (wb_addr[j*AW +: AW] != '0))
        regs_d[wb_addr[j*AW +: AW]] = wb_data[j*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 1; r < NREG; r++) regs_q[r] <= XLEN'(REGS_INIT);
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_busy  = '0;
    ra       = '0;
    fwd      = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      ra       = rd_addr[i*AW +: AW];
      fwd      = 1'b0;
      fwd_data = '0;
      if (BYPASS) begin
        for (int j = 0; j < NWR; j++) begin
          if (wb_valid[j] && (wb_addr[j*AW +: AW] == ra)) begin
            fwd      = 1'b1;
            fwd_data = wb_data[j*XLEN +: XLEN];
          end
        end
      end
      if (rd_en[i] && (ra != '0)) begin
        if (fwd) begin
          rd_data[i*XLEN +: XLEN] = fwd_data;
        end else begin
          rd_data[i*XLEN +: XLEN] = regs_q[ra];
          rd_busy[i]              = busy[ra];
        end
      end
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
endmodule

// File: tb/tb_ysyx_22040237_regfile_sb.sv
// tb/tb_ysyx_22040237_regfile_sb.sv - directed checks of the register file with and without bypass
module tb_ysyx_22040237_regfile_sb;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   rd_en;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data, rd_data_nb;
  logic [1:0]   rd_busy, rd_busy_nb;
  logic         iss_valid;
  logic [4:0]   iss_addr;
  logic         iss_ready, iss_ready_nb;
  logic [1:0]   wb_valid;
  logic [9:0]   wb_addr;
  logic [127:0] wb_data;
  logic [5:0]   busy_cnt, busy_cnt_nb;
  logic [4:0]   dbg_addr;
  logic [63:0]  dbg_data, dbg_data_nb;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ysyx_22040237_regfile_sb #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .busy_cnt(busy_cnt),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  ysyx_22040237_regfile_sb #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready_nb),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .busy_cnt(busy_cnt_nb),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid  = 2'b00;
    iss_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 2'b11; rd_addr = '0; iss_valid = 1'b0; iss_addr = '0;
    dbg_addr = '0;
    wb_valid = 2'b11; wb_addr = {5'd6, 5'd5};
    wb_data = {64'hDEAD_BEEF_0000_0006, 64'hDEAD_BEEF_0000_0005};
    step(); step();
    rst_n = 1'b1; idle();
    rd_addr = {5'd6, 5'd5}; iss_addr = 5'd5; dbg_addr = 5'd5; #1;
    chk("reset_r5", rd_data[63:0], 64'h0);
    chk("reset_r6", rd_data[127:64], 64'h0);
    chk("reset_cnt", 64'(busy_cnt), 64'd0);
    chk("reset_iss_ready", 64'(iss_ready), 64'd1);
    chk("reset_rd_busy", 64'(rd_busy), 64'd0);
    chk("reset_dbg", dbg_data, 64'h0);

    wb_valid = 2'b01; wb_addr = {5'd0, 5'd3}; wb_data = {64'h0, 64'h1234_5678_9abc_def0};
    rd_addr = {5'd0, 5'd3}; dbg_addr = 5'd3; #1;
    chk("bypass_r3", rd_data[63:0], 64'h1234_5678_9abc_def0);
    chk("nobypass_r3_old", rd_data_nb[63:0], 64'h0);
    chk("dbg_not_bypassed", dbg_data, 64'h0);
    step(); idle(); #1;
    chk("reg_r3", rd_data[63:0], 64'h1234_5678_9abc_def0);
    chk("reg_r3_nb", rd_data_nb[63:0], 64'h1234_5678_9abc_def0);
    chk("dbg_r3", dbg_data, 64'h1234_5678_9abc_def0);
    rd_en = 2'b10; #1;
    chk("rd_en_off", rd_data[63:0], 64'h0);
    rd_en = 2'b11;

    wb_valid = 2'b01; wb_addr = {5'd0, 5'd0}; wb_data = {64'h0, 64'hFF};
    iss_valid = 1'b1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0}; dbg_addr = 5'd0; #1;
    chk("x0_rd", rd_data[63:0], 64'h0);
    chk("x0_busy", 64'(rd_busy[0]), 64'd0);
    chk("x0_iss_ready", 64'(iss_ready), 64'd1);
    step(); idle(); #1;
    chk("x0_cnt", 64'(busy_cnt), 64'd0);
    chk("x0_dbg", dbg_data, 64'h0);

    iss_valid = 1'b1; iss_addr = 5'd7; rd_addr = {5'd0, 5'd7}; #1;
    chk("r7_iss_ready_free", 64'(iss_ready), 64'd1);
    chk("r7_not_busy_yet", 64'(rd_busy[0]), 64'd0);
    step(); idle(); #1;
    chk("r7_rd_busy", 64'(rd_busy[0]), 64'd1);
    chk("r7_iss_ready_busy", 64'(iss_ready), 64'd0);
    chk("r7_cnt", 64'(busy_cnt), 64'd1);
    wb_valid = 2'b01; wb_addr = {5'd0, 5'd7}; wb_data = {64'h0, 64'h55}; #1;
    chk("r7_wb_busy_clear", 64'(rd_busy[0]), 64'd0);
    chk("r7_wb_fwd", rd_data[63:0], 64'h55);
    chk("r7_wb_iss_ready", 64'(iss_ready), 64'd1);
    chk("r7_nb_still_busy", 64'(rd_busy_nb[0]), 64'd1);
    chk("r7_cnt_lag", 64'(busy_cnt), 64'd1);
    step(); idle(); #1;
    chk("r7_cnt_clear", 64'(busy_cnt), 64'd0);
    chk("r7_data", rd_data[63:0], 64'h55);

    wb_valid = 2'b11; wb_addr = {5'd9, 5'd9}; wb_data = {64'hB, 64'hA};
    rd_addr = {5'd9, 5'd0}; dbg_addr = 5'd9; #1;
    chk("coll_fwd", rd_data[127:64], 64'hB);
    step(); idle(); #1;
    chk("coll_dbg", dbg_data, 64'hB);
    chk("coll_rd", rd_data_nb[127:64], 64'hB);
    iss_valid = 1'b1; iss_addr = 5'd9;
    wb_valid = 2'b01; wb_addr = {5'd0, 5'd9}; wb_data = {64'h0, 64'hC}; #1;
    chk("coll_iss_ready", 64'(iss_ready), 64'd1);
    step(); idle(); #1;
    chk("coll_iss_dbg", dbg_data, 64'hC);
    chk("coll_iss_busy", 64'(rd_busy[1]), 64'd1);
    chk("coll_iss_cnt", 64'(busy_cnt), 64'd1);
    wb_valid = 2'b10; wb_addr = {5'd9, 5'd0}; wb_data = {64'hD, 64'h0};
    step(); idle(); #1;
    chk("r9_release_cnt", 64'(busy_cnt), 64'd0);

    for (int r = 1; r <= 4; r++) begin
      iss_valid = 1'b1; iss_addr = 5'(r);
      step();
    end
    idle(); rd_addr = {5'd2, 5'd1}; iss_addr = 5'd4; dbg_addr = 5'd3; #1;
    chk("multi_cnt", 64'(busy_cnt), 64'd4);
    chk("multi_rd_busy", 64'(rd_busy), 64'd3);
    chk("multi_iss_blocked", 64'(iss_ready), 64'd0);
    rst_n = 1'b0; wb_valid = 2'b01; wb_addr = {5'd0, 5'd1}; wb_data = {64'h0, 64'h77};
    step();
    rst_n = 1'b1; idle(); #1;
    chk("midrst_cnt", 64'(busy_cnt), 64'd0);
    chk("midrst_rd_busy", 64'(rd_busy), 64'd0);
    chk("midrst_r1", rd_data[63:0], 64'h0);
    chk("midrst_dbg_r3", dbg_data, 64'h0);
    chk("midrst_iss_ready", 64'(iss_ready), 64'd1);
    chk("midrst_nb_cnt", 64'(busy_cnt_nb), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
